// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and types for the D->E hazard/stall controller.
// Holds Tuse/Tnew encodings, mult/div latencies and the pipeline slot record.
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE       = 2'd3;
  localparam int         MULT_CYCLES_DEF = 5;
  localparam int         DIV_CYCLES_DEF  = 10;
  localparam int         CNT_W_DEF       = 4;

  // MIPS encodings of the instructions that drive the mult/div unit
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{a3: 5'd0, tnew: 2'd0};

  function automatic logic [1:0] sat_dec(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Busy-window counter for the multi-cycle mult/div unit.
// Loads the op latency the edge after the op sits in E, then counts down to zero.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             cancel,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // A cancelled start never loads; an already running count is left alone.
  always_comb begin
    cnt_next = cnt_reg;
    if (start && !cancel) begin
      cnt_next = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  assign busy = start | (cnt_reg != '0);
  assign cnt  = cnt_reg;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D->E issue controller: shadows E/M destination/Tnew to find uncoverable RAW hazards,
// tracks mult/div occupancy, and drives PC/F-D enables and the D/E bubble.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_A3,
  input  logic [1:0] D_tnew,
  input  logic       D_is_md,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       int_req,
  output logic       stall,
  output logic       pc_en,
  output logic       fd_en,
  output logic       de_clr,
  output logic       md_busy
);

  slot_t e_slot_reg, e_slot_next;
  slot_t m_slot_reg, m_slot_next;
  logic  e_md_start_reg, e_md_start_next;
  logic  e_md_div_reg, e_md_div_next;

  logic [4:0]       src  [2];
  logic [1:0]       tuse [2];
  logic [1:0]       hz_op;
  logic             hz_md;
  logic [CNT_W-1:0] md_cnt;

  assign src[0]  = D_rs;
  assign src[1]  = D_rt;
  assign tuse[0] = D_tuse_rs;
  assign tuse[1] = D_tuse_rt;

  // Only E and M producers can stall; once in W the value is always forwardable.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign hz_op[gi] = (src[gi] != 5'd0) && (tuse[gi] != TUSE_NONE) &&
                         (((src[gi] == e_slot_reg.a3) && (tuse[gi] < e_slot_reg.tnew)) ||
                          ((src[gi] == m_slot_reg.a3) && (tuse[gi] < m_slot_reg.tnew)));
    end
  endgenerate

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .start (e_md_start_reg),
    .is_div(e_md_div_reg),
    .cancel(int_req),
    .busy  (md_busy),
    .cnt   (md_cnt)
  );

  assign hz_md  = D_is_md & md_busy;
  assign stall  = (|hz_op | hz_md) & ~int_req;
  assign pc_en  = ~stall;
  assign fd_en  = ~stall;
  assign de_clr = stall;

  // A flush empties E and M outright; a stall only bubbles E.
  always_comb begin
    e_slot_next     = SLOT_EMPTY;
    m_slot_next     = SLOT_EMPTY;
    e_md_start_next = 1'b0;
    e_md_div_next   = 1'b0;
    if (!int_req) begin
      m_slot_next = '{a3: e_slot_reg.a3, tnew: sat_dec(e_slot_reg.tnew)};
      if (!stall) begin
        e_slot_next     = '{a3: D_A3, tnew: D_tnew};
        e_md_start_next = D_md_start;
        e_md_div_next   = D_md_div;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_slot_reg     <= SLOT_EMPTY;
      m_slot_reg     <= SLOT_EMPTY;
      e_md_start_reg <= 1'b0;
      e_md_div_reg   <= 1'b0;
    end else begin
      e_slot_reg     <= e_slot_next;
      m_slot_reg     <= m_slot_next;
      e_md_start_reg <= e_md_start_next;
      e_md_div_reg   <= e_md_div_next;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven bench for hazard_stall_ctrl with a queue of expected outputs per cycle.
// Each record is one D-stage cycle; rst marks the start of an independent scenario.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       D_is_md, D_md_start, D_md_div, int_req;
  logic       stall, pc_en, fd_en, de_clr, md_busy;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_tuse_rs (D_tuse_rs),
    .D_tuse_rt (D_tuse_rt),
    .D_A3      (D_A3),
    .D_tnew    (D_tnew),
    .D_is_md   (D_is_md),
    .D_md_start(D_md_start),
    .D_md_div  (D_md_div),
    .int_req   (int_req),
    .stall     (stall),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .de_clr    (de_clr),
    .md_busy   (md_busy)
  );

  typedef struct {
    bit         rst;
    logic [4:0] rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic [1:0] tuse_rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       is_md, md_start, md_div, irq;
    logic       exp_stall, exp_busy;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         n_pass = 0;
  int         n_total = 0;

  function automatic vec_t mk(input bit rst, input int rs, input int tu_rs, input int rt,
                              input int tu_rt, input int a3, input int tnew, input bit is_md,
                              input bit md_start, input bit md_div, input bit irq,
                              input bit es, input bit eb);
    vec_t v;
    v.rst = rst;         v.rs = 5'(rs);        v.tuse_rs = 2'(tu_rs);
    v.rt = 5'(rt);       v.tuse_rt = 2'(tu_rt); v.a3 = 5'(a3);
    v.tnew = 2'(tnew);   v.is_md = is_md;      v.md_start = md_start;
    v.md_div = md_div;   v.irq = irq;          v.exp_stall = es;
    v.exp_busy = eb;
    return v;
  endfunction

  // {stall, pc_en, fd_en, de_clr, md_busy}
  function automatic logic [4:0] pack_exp(input logic s, input logic b);
    return {s, ~s, ~s, s, b};
  endfunction

  task automatic drive(input vec_t v);
    D_rs = v.rs;       D_tuse_rs = v.tuse_rs; D_rt = v.rt;   D_tuse_rt = v.tuse_rt;
    D_A3 = v.a3;       D_tnew = v.tnew;       D_is_md = v.is_md;
    D_md_start = v.md_start; D_md_div = v.md_div; int_req = v.irq;
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("%0t %s: outs=%b ok", $time, name, got);
    end else begin
      $display("%0t FAIL %s: got {stall,pc_en,fd_en,de_clr,md_busy}=%b required=%b",
               $time, name, got, exp);
    end
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    check("in_reset", {stall, pc_en, fd_en, de_clr, md_busy}, 5'b01100);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [4:0] exp;
    if (v.rst) do_reset();
    drive(v);
    exp_q.push_back(pack_exp(v.exp_stall, v.exp_busy));
    @(negedge clk);
    exp = exp_q.pop_front();
    check($sformatf("vec%0d", idx), {stall, pc_en, fd_en, de_clr, md_busy}, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));

    //            rst rs tu rt tu a3 tn md st dv irq  s  b
    // lw $1 then addu $2,$1,$3 (Tuse 1): one stall while lw is in E
    vecs.push_back(mk(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 1, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    // ori $1 / beq $1,$0 (Tuse 0) stalls once; sub with Tuse 1 does not; rt path; M-stage stall
    vecs.push_back(mk(1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 6, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 7, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    // $0 destinations/sources and Tuse=3 never stall
    vecs.push_back(mk(1, 0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 3, 5, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 3, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 3, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    // mult then mflo: 6 stall cycles
    vecs.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    // div then mflo: 11 stall cycles
    vecs.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 11; i++) vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0));
    // flush while mult in E: stall dropped, counter never loads
    vecs.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    // flush clears the M slot too (Tuse 0 would otherwise hit M.tnew=1)
    vecs.push_back(mk(1, 0, 1, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3, 2, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3, 2, 1, 0, 0, 0, 0, 0, 0));
    // flush with counter already running: it keeps counting
    vecs.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 1, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0));
    // stalled div behind mult must not start the unit until it really issues
    vecs.push_back(mk(1, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 1, 1, 2, 1, 0, 0, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Async reset in the middle of a div (counter at 7), no clock edge in between
    run_vec(mk(1, 1, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0), 1000);
    for (int i = 0; i < 4; i++) run_vec(mk(0, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0, 1, 1), 1001 + i);
    check("pre_async_reset", {stall, pc_en, fd_en, de_clr, md_busy}, 5'b10011);
    #1 reset = 1'b0;
    #1;
    check("async_reset", {stall, pc_en, fd_en, de_clr, md_busy}, 5'b01100);
    #1 reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
